// File: rtl/spi_ram_rw_ctrl.sv
// SPI mode-0 transaction engine for 23LC-style serial SRAMs: READ / FAST READ / WRITE of a full word.
// One bit every two clocks (SCK low, SCK high); MISO is sampled on the edge that raises SCK.
module spi_ram_rw_ctrl #(
  parameter int ADDR_BITS  = 16,
  parameter int DATA_BYTES = 4,
  parameter bit FAST_READ  = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    write,
  input  logic [ADDR_BITS-1:0]    addr,
  input  logic [8*DATA_BYTES-1:0] wdata,
  output logic [8*DATA_BYTES-1:0] rdata,
  output logic                    busy,
  output logic                    done,
  output logic                    spi_select,
  output logic                    spi_clk_out,
  output logic                    spi_mosi,
  input  logic                    spi_miso
);
  localparam int DW = 8 * DATA_BYTES;
  localparam int TW = 16 + ADDR_BITS + DW;
  localparam logic [7:0] RD_CMD = FAST_READ ? 8'h0B : 8'h03;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, END} state_t;

  state_t         state, state_n;
  logic           phase;
  logic [6:0]     cnt;
  logic [6:0]     len;
  logic           last_bit;
  logic           accept;
  logic           wr_q;
  logic [TW-1:0]  tx;
  logic [DW-1:0]  rx;

  always_comb begin
    len = 7'd8;
    case (state)
      ADDR:    len = 7'(ADDR_BITS);
      DATA:    len = 7'(DW);
      default: len = 7'd8;
    endcase
  end

  assign last_bit = phase && (cnt == len - 7'd1);
  // END has busy=0, so a start there chains straight into the next command.
  assign accept   = start && (state == IDLE || state == END);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE, END: state_n = accept ? CMD : IDLE;
      CMD:       if (last_bit) state_n = ADDR;
      ADDR:      if (last_bit) state_n = (FAST_READ && !wr_q) ? DUMMY : DATA;
      DUMMY:     if (last_bit) state_n = DATA;
      DATA:      if (last_bit) state_n = END;
      default:   state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= 1'b0;
      cnt   <= '0;
      wr_q  <= 1'b0;
      tx    <= '0;
      rx    <= '0;
      rdata <= '0;
    end else if (accept) begin
      phase <= 1'b0;
      cnt   <= '0;
      wr_q  <= write;
      // Whole frame is preloaded MSB-first; read frames carry zeros through DUMMY and DATA.
      tx    <= write ? {8'h02, addr, wdata, 8'h00} : {RD_CMD, addr, {(DW+8){1'b0}}};
    end else if (busy) begin
      phase <= ~phase;
      if (phase) begin
        tx  <= {tx[TW-2:0], 1'b0};
        cnt <= last_bit ? 7'd0 : cnt + 7'd1;
        if (state == DATA && last_bit && !wr_q) rdata <= rx;
      end else if (state == DATA && !wr_q) begin
        rx <= {rx[DW-2:0], spi_miso};
      end
    end
  end

  always_comb begin
    busy        = (state == CMD) || (state == ADDR) || (state == DUMMY) || (state == DATA);
    done        = (state == END);
    spi_select  = !busy;
    spi_clk_out = busy && phase;
    spi_mosi    = busy && tx[TW-1];
  end

endmodule

// File: tb/tb_spi_ram_rw_ctrl.sv
// Bench for spi_ram_rw_ctrl: default build and a FAST_READ/24-bit/2-byte build, each with an SPI RAM model.
// Expected frames and read data come from a byte-array RAM model; a monitor checks each done pulse.
module tb_spi_ram_rw_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc    = 0;
  int passed = 0;
  int total  = 0;
  bit fin [2];

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [127:0] bits;
    int           n;
    logic [63:0]  rdata;
    int           due;
  } exp_t;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int AB    = (g == 0) ? 16 : 24;
    localparam int DB    = (g == 0) ? 4 : 2;
    localparam bit FR    = (g == 0) ? 1'b0 : 1'b1;
    localparam int DW    = 8 * DB;
    localparam int MASK  = (1 << AB) - 1;
    localparam int DIR_A = (g == 0) ? 32'h1234 : 32'h012345;
    localparam logic [63:0] DIR_D = (g == 0) ? 64'hDEADBEEF : 64'hA55A;

    logic          rst   = 1'b1;
    logic          start = 1'b0;
    logic          write = 1'b0;
    logic          miso  = 1'b0;
    logic [AB-1:0] addr  = '0;
    logic [DW-1:0] wdata = '0;
    logic [DW-1:0] rdata;
    logic          busy, done, sel, sck, mosi;

    spi_ram_rw_ctrl #(.ADDR_BITS(AB), .DATA_BYTES(DB), .FAST_READ(FR)) dut (
      .clk(clk), .rst(rst), .start(start), .write(write), .addr(addr), .wdata(wdata),
      .rdata(rdata), .busy(busy), .done(done), .spi_select(sel), .spi_clk_out(sck),
      .spi_mosi(mosi), .spi_miso(miso)
    );

    exp_t         sb [$];
    logic [7:0]   smem [int];
    logic [7:0]   rmem [int];
    logic [127:0] cap;
    int           nsck, ncs, bitn, sa, hdr, j;
    logic         sck_prev;
    logic [7:0]   scmd, b;
    logic [63:0]  last_rd = '0;

    function automatic string nm(input string s);
      return $sformatf("u%0d.%s", g, s);
    endfunction

    function automatic logic [7:0] rd_s(input int a);
      return smem.exists(a) ? smem[a] : (8'(a) ^ 8'h5A);
    endfunction

    function automatic logic [7:0] rd_r(input int a);
      return rmem.exists(a) ? rmem[a] : (8'(a) ^ 8'h5A);
    endfunction

    // Monitor first (consumes the done pulse), then the SPI RAM slave model.
    always @(negedge clk) begin
      if (rst) begin
        cap = '0; nsck = 0; ncs = 0; bitn = 0; sck_prev = 1'b0; miso = 1'b0;
      end else begin
        if (done) begin
          if (sb.size() == 0) begin
            chk(nm("spurious_done"), 1, 0);
          end else begin
            exp_t e;
            e = sb.pop_front();
            chk(nm("rdata"), 128'(rdata), 128'(e.rdata));
            chk(nm("done_cycle"), cyc, e.due);
            chk(nm("mosi_bits"), cap, e.bits);
            chk(nm("sck_pulses"), nsck, e.n);
            chk(nm("cs_low_cycles"), ncs, 2 * e.n);
            chk(nm("end_pins"), {sel, sck, busy, mosi}, 4'b1000);
          end
          cap = '0; nsck = 0; ncs = 0;
        end
        if (!sel) begin
          ncs++;
          if (sck && !sck_prev) begin
            cap = {cap[126:0], mosi};
            nsck++;
            bitn++;
            if (bitn == 8) scmd = cap[7:0];
            if (bitn == 8 + AB) sa = int'(cap[AB-1:0]);
            if (scmd == 8'h02 && bitn > 8 + AB && (bitn - 8 - AB) % 8 == 0)
              smem[(sa + (bitn - 8 - AB) / 8 - 1) & MASK] = cap[7:0];
          end
          if (!sck) begin
            hdr = 8 + AB + ((scmd == 8'h0B) ? 8 : 0);
            if (bitn >= 8 && bitn >= hdr && scmd != 8'h02) begin
              j = bitn - hdr;
              b = rd_s((sa + j / 8) & MASK);
              miso = b[7 - j % 8];
            end else begin
              miso = 1'b0;
            end
          end
        end else begin
          bitn = 0;
        end
        sck_prev = sck;
      end
    end

    task automatic issue(input bit w, input logic [AB-1:0] a, input logic [DW-1:0] d,
                         input bit in_end, output int acc);
      exp_t        e;
      int          n;
      logic [63:0] r;
      if (in_end) begin
        for (int i = 0; i < 400 && !done; i++) @(negedge clk);
        chk(nm("end_wait"), done, 1);
      end else begin
        for (int i = 0; i < 400 && (busy || done); i++) @(negedge clk);
        chk(nm("idle_wait"), {busy, done}, 2'b00);
      end
      start = 1'b1; write = w; addr = a; wdata = d;
      @(negedge clk);
      start = 1'b0;
      acc   = cyc;
      chk(nm("first_cycle"), {sel, sck, busy, mosi}, 4'b0010);
      write = 1'($urandom);
      addr  = AB'($urandom);
      wdata = DW'({$urandom, $urandom});
      n = 8 + AB + ((FR && !w) ? 8 : 0) + DW;
      e.bits = 128'(w ? 8'h02 : (FR ? 8'h0B : 8'h03));
      e.bits = (e.bits << AB) | 128'(a);
      if (FR && !w) e.bits = e.bits << 8;
      e.bits = (e.bits << DW) | (w ? 128'(d) : 128'(0));
      if (w) begin
        for (int i = 0; i < DB; i++) rmem[(int'(a) + i) & MASK] = 8'(d >> (8 * (DB - 1 - i)));
      end else begin
        r = '0;
        for (int i = 0; i < DB; i++) r = (r << 8) | 64'(rd_r((int'(a) + i) & MASK));
        last_rd = r;
      end
      e.rdata = last_rd;
      e.n     = n;
      e.due   = acc + 2 * n;
      sb.push_back(e);
    endtask

    initial begin : stim
      int acc;
      rst = 1'b1; start = 1'b1;
      repeat (2) @(negedge clk);
      chk(nm("reset_pins"), {sel, sck, mosi, busy, done}, 5'b10000);
      chk(nm("reset_rdata"), 128'(rdata), 128'(0));
      rst = 1'b0; start = 1'b0;
      for (int i = 0; i < DB; i++) begin
        smem[DIR_A + i] = 8'(DIR_D >> (8 * (DB - 1 - i)));
        rmem[DIR_A + i] = 8'(DIR_D >> (8 * (DB - 1 - i)));
      end
      issue(1'b0, AB'(DIR_A), '0, 1'b0, acc);
      issue(1'b1, AB'(32'h00FF), DW'(64'hCAFE0001), 1'b0, acc);
      issue(1'b0, AB'(32'h00FF), '0, 1'b0, acc);
      for (int k = 0; k < 16; k++)
        issue(bit'($urandom_range(0, 1)), AB'($urandom_range(0, 47)), DW'({$urandom, $urandom}),
              bit'($urandom_range(0, 1)), acc);

      // A start pulse in the middle of a transfer must be dropped.
      issue(1'b0, AB'(32'h10), '0, 1'b0, acc);
      while (cyc < acc + 49) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;

      // Reset in the middle of a read aborts it with no done pulse.
      issue(1'b0, AB'(32'h20), '0, 1'b0, acc);
      while (cyc < acc + 29) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk(nm("abort_pins"), {sel, sck, busy, done}, 4'b1000);
      chk(nm("abort_rdata"), 128'(rdata), 128'(0));
      sb.delete();
      last_rd = '0;
      rst = 1'b0;
      repeat (150) @(negedge clk);
      issue(1'b0, AB'(32'h00FF), '0, 1'b0, acc);
      for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk);
      chk(nm("drain"), sb.size(), 0);
      fin[g] = 1'b1;
    end
  end

  initial begin
    for (int i = 0; i < 20000 && !(fin[0] && fin[1]); i++) @(negedge clk);
    if (!(fin[0] && fin[1])) begin
      total++;
      $display("FAIL timeout: finished %0d%0d want 11", fin[0], fin[1]);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
